// File: rtl/montgomery_exp_window.sv
// Constant-time x^e mod m using fixed-window left-to-right exponentiation over a
// radix-2 bit-serial Montgomery multiplier; R^2 mod m is derived internally.
module montgomery_exp_window #(
    parameter int WORD_WIDTH = 32,
    parameter int E_WIDTH    = 17,
    parameter int WINDOW     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] x,
    input  logic [E_WIDTH-1:0]    e,
    input  logic [WORD_WIDTH-1:0] m,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WORD_WIDTH-1:0] exp_result
);

    localparam int NW    = (E_WIDTH + WINDOW - 1) / WINDOW;
    localparam int TSIZE = 1 << WINDOW;
    localparam int EXT   = NW * WINDOW;
    localparam int MCW   = $clog2(WORD_WIDTH + 1);
    localparam int RCW   = $clog2(2 * WORD_WIDTH + 1);
    localparam int SQW   = $clog2(WINDOW + 1);
    localparam int WIW   = $clog2(NW + 1);

    typedef enum logic [2:0] {IDLE, R2, TOMONT, TABLE, EXP, FROMMONT, DONE} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] x_reg, m_reg, v, r2, a_sh, b_op;
    logic [EXT-1:0]        e_sh;
    logic [WORD_WIDTH+1:0] t;
    logic [MCW-1:0]        mm_cnt;
    logic [RCW-1:0]        r2_cnt;
    logic [WORD_WIDTH-1:0] tbl [TSIZE];
    logic                  phase, fin;
    logic [WINDOW-1:0]     tbl_idx;
    logic [SQW-1:0]        sq_cnt;
    logic [WIW-1:0]        win_idx;

    logic [WORD_WIDTH+1:0] t_add, t_odd, t_step;
    logic [WORD_WIDTH-1:0] mm_res, v_next;
    logic [WORD_WIDTH:0]   v_dbl;
    logic [WINDOW-1:0]     digit;
    logic                  mm_last;

    // One multiplier iteration, the final conditional subtraction, and one R2 doubling.
    always_comb begin
        t_add   = t + (a_sh[0] ? {2'b00, b_op} : '0);
        t_odd   = t_add[0] ? t_add + {2'b00, m_reg} : t_add;
        t_step  = t_odd >> 1;
        mm_res  = WORD_WIDTH'((t >= {2'b00, m_reg}) ? t - {2'b00, m_reg} : t);
        v_dbl   = {v, 1'b0};
        v_next  = (v_dbl >= {1'b0, m_reg}) ? WORD_WIDTH'(v_dbl - {1'b0, m_reg})
                                           : v_dbl[WORD_WIDTH-1:0];
        digit   = e_sh[EXT-1 -: WINDOW];
        mm_last = (mm_cnt == MCW'(WORD_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            exp_result <= '0;
            fin        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (enable) begin
                        x_reg  <= x;
                        m_reg  <= m;
                        e_sh   <= EXT'(e);
                        done   <= 1'b0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        v      <= WORD_WIDTH'(1);
                        r2_cnt <= '0;
                        fin    <= 1'b0;
                        state  <= R2;
                    end
                end
                R2: begin
                    // The first cycle only screens the modulus; doublings follow.
                    if (r2_cnt == '0) begin
                        if (!m_reg[0]) begin
                            done       <= 1'b1;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            exp_result <= '0;
                            state      <= DONE;
                        end else begin
                            r2_cnt <= r2_cnt + 1'b1;
                        end
                    end else begin
                        v      <= v_next;
                        r2_cnt <= r2_cnt + 1'b1;
                        if (r2_cnt == RCW'(2 * WORD_WIDTH)) begin
                            r2     <= v_next;
                            a_sh   <= WORD_WIDTH'(1);
                            b_op   <= v_next;
                            t      <= '0;
                            mm_cnt <= '0;
                            phase  <= 1'b0;
                            state  <= TOMONT;
                        end
                    end
                end
                default: begin
                    if (fin) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (!mm_last) begin
                        t      <= t_step;
                        a_sh   <= a_sh >> 1;
                        mm_cnt <= mm_cnt + 1'b1;
                    end else begin
                        // Product complete: store it and queue the next multiplication.
                        t      <= '0;
                        mm_cnt <= '0;
                        case (state)
                            TOMONT: begin
                                if (!phase) begin
                                    tbl[0] <= mm_res;
                                    a_sh   <= x_reg;
                                    b_op   <= r2;
                                    phase  <= 1'b1;
                                end else begin
                                    tbl[1] <= mm_res;
                                    if (TSIZE > 2) begin
                                        a_sh    <= mm_res;
                                        b_op    <= mm_res;
                                        tbl_idx <= WINDOW'(2);
                                        state   <= TABLE;
                                    end else begin
                                        a_sh    <= tbl[0];
                                        b_op    <= tbl[0];
                                        sq_cnt  <= '0;
                                        win_idx <= WIW'(NW - 1);
                                        state   <= EXP;
                                    end
                                end
                            end
                            TABLE: begin
                                tbl[tbl_idx] <= mm_res;
                                if (tbl_idx == WINDOW'(TSIZE - 1)) begin
                                    a_sh    <= tbl[0];
                                    b_op    <= tbl[0];
                                    sq_cnt  <= '0;
                                    win_idx <= WIW'(NW - 1);
                                    state   <= EXP;
                                end else begin
                                    tbl_idx <= tbl_idx + 1'b1;
                                    a_sh    <= mm_res;
                                    b_op    <= tbl[1];
                                end
                            end
                            EXP: begin
                                // Zero digits still multiply by T[0] to keep timing flat.
                                if (sq_cnt == SQW'(WINDOW)) begin
                                    a_sh   <= mm_res;
                                    sq_cnt <= '0;
                                    if (win_idx == '0) begin
                                        b_op  <= WORD_WIDTH'(1);
                                        state <= FROMMONT;
                                    end else begin
                                        b_op    <= mm_res;
                                        win_idx <= win_idx - 1'b1;
                                    end
                                end else if (sq_cnt == SQW'(WINDOW - 1)) begin
                                    a_sh   <= mm_res;
                                    b_op   <= tbl[digit];
                                    e_sh   <= e_sh << WINDOW;
                                    sq_cnt <= SQW'(WINDOW);
                                end else begin
                                    a_sh   <= mm_res;
                                    b_op   <= mm_res;
                                    sq_cnt <= sq_cnt + 1'b1;
                                end
                            end
                            default: begin
                                exp_result <= mm_res;
                                fin        <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_exp_window.sv
// Scoreboard bench for montgomery_exp_window at default parameters: results,
// exact latency, error handling, reset abort and ignored mid-run enables.
module tb_montgomery_exp_window;

    localparam int W     = 32;
    localparam int EW    = 17;
    localparam int LAT   = 2 * 32 + 42 * 33 + 2;
    localparam int LIMIT = 3000;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [W-1:0]  x;
    logic [EW-1:0] e;
    logic [W-1:0]  m;
    logic          busy;
    logic          done;
    logic          error;
    logic [W-1:0]  exp_result;

    int n_checks;
    int n_pass;
    logic [W-1:0] exp_q [$];

    montgomery_exp_window #(.WORD_WIDTH(W), .E_WIDTH(EW), .WINDOW(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .e(e), .m(m),
        .busy(busy), .done(done), .error(error), .exp_result(exp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain LSB-first square-and-multiply reference.
    function automatic logic [W-1:0] model(input logic [W-1:0] xv, input logic [EW-1:0] ev,
                                           input logic [W-1:0] mv);
        longint unsigned r, b, mm;
        mm = 64'(mv);
        r  = 64'd1 % mm;
        b  = 64'(xv) % mm;
        for (int i = 0; i < EW; i++) begin
            if (ev[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return W'(r);
    endfunction

    task automatic launch(input logic [W-1:0] xv, input logic [EW-1:0] ev, input logic [W-1:0] mv);
        @(negedge clk);
        x = xv; e = ev; m = mv; enable = 1'b1;
        if (mv[0]) exp_q.push_back(model(xv, ev, mv));
        else       exp_q.push_back('0);
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit busy_ok);
        bit seen;
        seen    = 1'b0;
        busy_ok = 1'b1;
        cycles  = LIMIT + 1;
        for (int i = 1; i <= LIMIT && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen   = 1'b1;
                cycles = i;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; x = '0; e = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("[TB] FAIL reset_error: got %b, expected 0", error); else n_pass++;
        n_checks++; if (exp_result !== '0) $display("[TB] FAIL reset_result: got %0d, expected 0", exp_result); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc; bit bok; logic [W-1:0] want;
        launch(32'd5, 17'd3, 32'd7);
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_start: got %b, expected 1", busy); else n_pass++;
        wait_done(cyc, bok);
        want = exp_q.pop_front();
        n_checks++; if (want !== 32'd6) $display("[TB] FAIL basic_model: got %0d, expected 6", want); else n_pass++;
        n_checks++; if (exp_result !== want) $display("[TB] FAIL basic_result: got %0d, expected %0d", exp_result, want); else n_pass++;
        n_checks++; if (cyc !== LAT) $display("[TB] FAIL basic_latency: got %0d, expected %0d", cyc, LAT); else n_pass++;
        n_checks++; if (bok !== 1'b1) $display("[TB] FAIL basic_busy_held: got %b, expected 1", bok); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("[TB] FAIL basic_error: got %b, expected 0", error); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]  xs [4] = '{32'd2, 32'd3, 32'd7, 32'd0};
        logic [EW-1:0] es [4] = '{17'd10, 17'd65536, 17'd0, 17'd5};
        logic [W-1:0]  ms [4] = '{32'd1000003, 32'd65537, 32'd13, 32'd13};
        logic [W-1:0]  fixed [4] = '{32'd1024, 32'd1, 32'd1, 32'd0};
        int cyc; bit bok; logic [W-1:0] want;
        for (int i = 0; i < 4; i++) begin
            launch(xs[i], es[i], ms[i]);
            n_checks++; if (done !== 1'b0) $display("[TB] FAIL b2b_done_clear[%0d]: got %b, expected 0", i, done); else n_pass++;
            wait_done(cyc, bok);
            want = exp_q.pop_front();
            n_checks++; if (exp_result !== fixed[i]) $display("[TB] FAIL b2b_result[%0d]: got %0d, expected %0d", i, exp_result, fixed[i]); else n_pass++;
            n_checks++; if (exp_result !== want) $display("[TB] FAIL b2b_model[%0d]: got %0d, expected %0d", i, exp_result, want); else n_pass++;
            n_checks++; if (cyc !== LAT) $display("[TB] FAIL b2b_latency[%0d]: got %0d, expected %0d", i, cyc, LAT); else n_pass++;
            n_checks++; if (bok !== 1'b1) $display("[TB] FAIL b2b_busy_held[%0d]: got %b, expected 1", i, bok); else n_pass++;
        end
    endtask

    task automatic test_even_modulus;
        int cyc; bit bok; logic [W-1:0] want;
        launch(32'd3, 17'd4, 32'd10);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        n_checks++; if (done !== 1'b1) $display("[TB] FAIL even_done: got %b, expected 1", done); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("[TB] FAIL even_error: got %b, expected 1", error); else n_pass++;
        n_checks++; if (exp_result !== want) $display("[TB] FAIL even_result: got %0d, expected %0d", exp_result, want); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL even_busy: got %b, expected 0", busy); else n_pass++;
        launch(32'd5, 17'd3, 32'd7);
        n_checks++; if (error !== 1'b0) $display("[TB] FAIL even_error_clear: got %b, expected 0", error); else n_pass++;
        wait_done(cyc, bok);
        want = exp_q.pop_front();
        n_checks++; if (exp_result !== want) $display("[TB] FAIL even_recover_result: got %0d, expected %0d", exp_result, want); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("[TB] FAIL even_recover_error: got %b, expected 0", error); else n_pass++;
        n_checks++; if (cyc !== LAT) $display("[TB] FAIL even_recover_latency: got %0d, expected %0d", cyc, LAT); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int cyc; bit bok; logic [W-1:0] want;
        launch(32'd5, 17'd3, 32'd7);
        repeat (499) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b, expected 0", done); else n_pass++;
        n_checks++; if (exp_result !== '0) $display("[TB] FAIL abort_result: got %0d, expected 0", exp_result); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        launch(32'd5, 17'd3, 32'd7);
        wait_done(cyc, bok);
        want = exp_q.pop_front();
        n_checks++; if (exp_result !== want) $display("[TB] FAIL abort_restart_result: got %0d, expected %0d", exp_result, want); else n_pass++;
        n_checks++; if (cyc !== LAT) $display("[TB] FAIL abort_restart_latency: got %0d, expected %0d", cyc, LAT); else n_pass++;
    endtask

    task automatic test_enable_ignored;
        int cyc; bit seen; logic [W-1:0] want;
        launch(32'd5, 17'd3, 32'd7);
        seen = 1'b0;
        cyc  = LIMIT + 1;
        for (int i = 1; i <= LIMIT && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                cyc  = i;
            end
            enable = (i == 10 || i == 300);
            if (i == 10 || i == 300) x = 32'd4;
            if (i == 700) x = 32'd9;
        end
        enable = 1'b0;
        want = exp_q.pop_front();
        n_checks++; if (exp_result !== want) $display("[TB] FAIL ignore_result: got %0d, expected %0d", exp_result, want); else n_pass++;
        n_checks++; if (cyc !== LAT) $display("[TB] FAIL ignore_latency: got %0d, expected %0d", cyc, LAT); else n_pass++;
    endtask

    task automatic test_random;
        int cyc; bit bok; logic [W-1:0] want, xv, mv; logic [EW-1:0] ev;
        for (int i = 0; i < 6; i++) begin
            mv = $urandom | 32'h8000_0001;
            xv = $urandom % mv;
            ev = EW'($urandom);
            launch(xv, ev, mv);
            wait_done(cyc, bok);
            want = exp_q.pop_front();
            n_checks++; if (exp_result !== want) $display("[TB] FAIL rand_result[%0d]: got %0h, expected %0h (x=%0h e=%0h m=%0h)", i, exp_result, want, xv, ev, mv); else n_pass++;
            n_checks++; if (cyc !== LAT) $display("[TB] FAIL rand_latency[%0d]: got %0d, expected %0d", i, cyc, LAT); else n_pass++;
        end
    endtask

    task automatic test_reset_wins;
        @(negedge clk);
        reset = 1'b1; enable = 1'b1; x = 32'd5; e = 17'd3; m = 32'd7;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_wins_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_wins_done: got %b, expected 0", done); else n_pass++;
        @(negedge clk);
        reset = 1'b0; enable = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_wins_idle: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_even_modulus();
        test_reset_abort();
        test_enable_ignored();
        test_random();
        test_reset_wins();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/montgomery_exp_window.md
Name: montgomery_exp_window

Overview:
- Parametrised successor to montgomery_exp: computes exp_result = x^e mod m using fixed-window (2^WINDOW-ary) left-to-right exponentiation over an internal radix-2 bit-serial Montgomery multiplier.
- Computes R^2 mod m internally (R = 2^WORD_WIDTH), so no R input is needed.
- Latency is data-independent, so the RSA top level can use it for constant-time private-key operations.

Parameters:
- WORD_WIDTH, 32, width of x, m and exp_result.
- E_WIDTH, 17, width of exponent e.
- WINDOW, 4, exponent window size in bits; legal range 1..6.

Ports:
- clk  in  1  clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start request; sampled only in IDLE.
- x  in  WORD_WIDTH  base; must satisfy x < m.
- e  in  E_WIDTH  exponent.
- m  in  WORD_WIDTH  modulus; must be odd and > 1.
- busy  out  1  high while a computation is in progress.
- done  out  1  result valid; held high until the next accepted enable or reset.
- error  out  1  high with done when m was even.
- exp_result  out  WORD_WIDTH  result; held stable while done=1.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, error=0, exp_result=0. Reset at any cycle, including mid-operation, aborts the operation within the same edge. No partial result is ever flagged.
- Start: in IDLE or DONE, enable=1 at edge k latches x, e and m, clears done and error, and sets busy=1. Input changes after edge k are ignored. enable while busy=1 is ignored.
- Even modulus: if the latched m[0]=0, at edge k+1 the block sets done=1, error=1, exp_result=0, busy=0, and does no computation.
- MM(a,b) = a*b*2^-WORD_WIDTH mod m, bit-serial:
  - Accumulator t is WORD_WIDTH+2 bits, starting at 0.
  - For i = 0..WORD_WIDTH-1: t = t + a[i]*b; if t is odd, t = t + m; t = t >> 1.
  - One extra cycle: if t >= m, t = t - m.
  - Each MM takes exactly WORD_WIDTH+1 cycles.
- FSM states: IDLE, R2, TOMONT, TABLE, EXP, FROMMONT, DONE.
  - R2, 2*WORD_WIDTH cycles: v=1, then repeat 2*WORD_WIDTH times: v = 2v; if v >= m, v = v - m. Result is R^2 mod m.
  - TOMONT, 2 MMs: one_bar = MM(1, R2) and x_bar = MM(x, R2).
  - TABLE, 2^WINDOW - 2 MMs: T[0] = one_bar, T[1] = x_bar, T[i] = MM(T[i-1], x_bar) for i = 2..2^WINDOW-1.
  - EXP: e is zero-extended to NW*WINDOW bits, NW = ceil(E_WIDTH/WINDOW). acc = one_bar. For each window, most-significant first: WINDOW squarings acc = MM(acc, acc), then acc = MM(acc, T[digit]). The multiply is performed even when digit = 0, so every window costs WINDOW+1 MMs.
  - FROMMONT, 1 MM: exp_result = MM(acc, 1).
  - DONE: done=1, busy=0; stays here until enable (new start) or reset.
- Latency:
  - N_MM = 2 + (2^WINDOW - 2) + NW*(WINDOW+1) + 1.
  - With enable accepted at edge k, done rises at edge k + L, where L = 2*WORD_WIDTH + N_MM*(WORD_WIDTH+1) + 2.
  - L is exact and independent of x, e and m.
  - Defaults: NW=5, N_MM=42, L=1452.
- Edge cases:
  - e = 0 gives result 1.
  - x = 0 with e > 0 gives result 0.
  - x >= m is outside the contract; the result is unspecified, but the FSM must still reach DONE at L.
  - Simultaneous reset and enable: reset wins.

Test Plan:
- Defaults; x=5, e=3, m=7 -> exp_result=6, done rises exactly 1452 cycles after enable, busy=1 throughout, error=0.
- x=2, e=10, m=1000003 -> 1024. Then x=3, e=65536, m=65537 -> 1. Then x=7, e=0, m=13 -> 1. Then x=0, e=5, m=13 -> 0. All run back-to-back without reset, restarting from DONE, each with latency 1452.
- enable with m=10 -> next cycle done=1, error=1, exp_result=0, busy=0. A following valid start clears error.
- Start x=5, e=3, m=7; assert reset 500 cycles later -> same edge busy=0, done=0, exp_result=0. A new start then returns 6 after 1452 cycles.
- Pulse enable with x=4 at cycles 10 and 300 of a run x=5, e=3, m=7 (and change x mid-run) -> second enable ignored, result still 6 at 1452.
- Instantiate WORD_WIDTH=64, E_WIDTH=64, WINDOW=1 and compare 1000 random odd-m vectors against the Python golden model from the existing test-vector flow -> all match, latency per formula.
